// File: rtl/dma_pkg.sv
// Shared definitions for the MIG DMA engines: app_cmd encodings, default address step
// and the write-engine state encoding.
package dma_pkg;

  localparam logic [2:0] APP_CMD_WR    = 3'b000;
  localparam logic [2:0] APP_CMD_RD    = 3'b001;
  localparam int         ADDR_STEP_DEF = 8;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_XFER,
    WR_DONE
  } wr_state_e;

endpackage

// File: rtl/app_dma_wr.sv
// DMA write engine: FWFT FIFO -> DDR3 MIG user interface, independent command and data paths.
// Optional byte mask input from the FIFO word is enabled with `define DMA_WR_MASK_EN.
import dma_pkg::*;

module app_dma_wr #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 256,
  parameter int LEN_W     = 8,
  parameter int ADDR_STEP = ADDR_STEP_DEF
) (
  input  logic                I_sys_clk,
  input  logic                I_Rst_n,
  input  logic                ex_wr_start,
  input  logic [ADDR_W-1:0]   ex_wr_addr,
  input  logic [LEN_W-1:0]    ex_wr_burst_len,
  input  logic [DATA_W-1:0]   ex_wr_data,
`ifdef DMA_WR_MASK_EN
  input  logic [DATA_W/8-1:0] ex_wr_mask,
`endif
  input  logic                ex_wr_empty,
  output logic                ex_wr_rd_en,
  output logic                ex_wr_burst_start,
  output logic                ex_wr_burst_end,
  output logic                ex_wr_busy,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  input  logic                app_rdy,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_rdy
);

  wr_state_e         state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cmd_cnt;
  logic [LEN_W-1:0]  data_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              en_q;
  logic              burst_end_q;
  logic              accept;
  logic              cmd_hs;
  logic              data_hs;
  logic              xfer_done;

  assign accept    = (state_q == WR_IDLE) && ex_wr_start && (ex_wr_burst_len != '0);
  assign cmd_hs    = en_q && app_rdy;
  assign data_hs   = app_wdf_wren && app_wdf_rdy;
  assign xfer_done = (cmd_cnt == len_q) && (data_cnt == len_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      WR_IDLE: if (accept) state_d = WR_XFER;
      WR_XFER: if (xfer_done) state_d = WR_DONE;
      WR_DONE: state_d = WR_IDLE;
      default: state_d = WR_IDLE;
    endcase
  end

  // Command and data counters advance independently; either side may lead the other.
  always_ff @(posedge I_sys_clk or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      state_q     <= WR_IDLE;
      len_q       <= '0;
      cmd_cnt     <= '0;
      data_cnt    <= '0;
      addr_q      <= '0;
      en_q        <= 1'b0;
      burst_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_end_q <= (state_d == WR_DONE);
      if (accept) begin
        addr_q   <= ex_wr_addr;
        len_q    <= ex_wr_burst_len;
        cmd_cnt  <= '0;
        data_cnt <= '0;
        en_q     <= 1'b1;
      end else begin
        if (cmd_hs) begin
          addr_q  <= addr_q + ADDR_W'(ADDR_STEP);
          cmd_cnt <= cmd_cnt + LEN_W'(1);
          if (cmd_cnt + LEN_W'(1) == len_q) en_q <= 1'b0;
        end
        if (data_hs) data_cnt <= data_cnt + LEN_W'(1);
      end
    end
  end

  assign ex_wr_burst_start = accept;
  assign ex_wr_burst_end   = burst_end_q;
  assign ex_wr_busy        = (state_q != WR_IDLE);
  assign app_addr          = addr_q;
  assign app_cmd           = APP_CMD_WR;
  assign app_en            = en_q;

  // The FIFO is first-word-fall-through, so its head word is presented straight to the MIG.
  assign app_wdf_wren = (state_q == WR_XFER) && (data_cnt < len_q) && !ex_wr_empty;
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_data = ex_wr_data;
  assign ex_wr_rd_en  = data_hs;

`ifdef DMA_WR_MASK_EN
  assign app_wdf_mask = ex_wr_mask;
`else
  assign app_wdf_mask = '0;
`endif

endmodule

// File: tb/tb_app_dma_wr.sv
// Self-checking bench for app_dma_wr: FWFT FIFO model, command/data scoreboards,
// table-driven bursts plus hand-written stall, re-entry and reset sequences.
`timescale 1ns/1ps
module tb_app_dma_wr;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 256;
  localparam int LEN_W  = 8;
  localparam int MASK_W = DATA_W/8;

  logic                I_sys_clk = 1'b0;
  logic                I_Rst_n;
  logic                ex_wr_start;
  logic [ADDR_W-1:0]   ex_wr_addr;
  logic [LEN_W-1:0]    ex_wr_burst_len;
  logic [DATA_W-1:0]   ex_wr_data;
  logic                ex_wr_empty;
  logic                ex_wr_rd_en;
  logic                ex_wr_burst_start;
  logic                ex_wr_burst_end;
  logic                ex_wr_busy;
  logic [ADDR_W-1:0]   app_addr;
  logic [2:0]          app_cmd;
  logic                app_en;
  logic                app_rdy;
  logic [DATA_W-1:0]   app_wdf_data;
  logic                app_wdf_wren;
  logic                app_wdf_end;
  logic [MASK_W-1:0]   app_wdf_mask;
  logic                app_wdf_rdy;
`ifdef DMA_WR_MASK_EN
  logic [MASK_W-1:0]   ex_wr_mask;
`endif

  always #5 I_sys_clk = ~I_sys_clk;

  app_dma_wr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ADDR_STEP(8)) dut (
    .I_sys_clk         (I_sys_clk),
    .I_Rst_n           (I_Rst_n),
    .ex_wr_start       (ex_wr_start),
    .ex_wr_addr        (ex_wr_addr),
    .ex_wr_burst_len   (ex_wr_burst_len),
    .ex_wr_data        (ex_wr_data),
`ifdef DMA_WR_MASK_EN
    .ex_wr_mask        (ex_wr_mask),
`endif
    .ex_wr_empty       (ex_wr_empty),
    .ex_wr_rd_en       (ex_wr_rd_en),
    .ex_wr_burst_start (ex_wr_burst_start),
    .ex_wr_burst_end   (ex_wr_burst_end),
    .ex_wr_busy        (ex_wr_busy),
    .app_addr          (app_addr),
    .app_cmd           (app_cmd),
    .app_en            (app_en),
    .app_rdy           (app_rdy),
    .app_wdf_data      (app_wdf_data),
    .app_wdf_wren      (app_wdf_wren),
    .app_wdf_end       (app_wdf_end),
    .app_wdf_mask      (app_wdf_mask),
    .app_wdf_rdy       (app_wdf_rdy)
  );

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [MASK_W-1:0] m;
  } beat_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [7:0]        pat;
    int                period;
    int                exp_cyc;
  } vec_t;

  // FWFT FIFO model feeding the DUT
  logic [DATA_W-1:0] fifo_data [0:63];
  logic [MASK_W-1:0] fifo_mask [0:63];
  logic [31:0]       rd_ptr = 0;
  logic [31:0]       wr_ptr = 0;
  logic              force_empty = 1'b0;

  assign ex_wr_data  = fifo_data[rd_ptr[5:0]];
  assign ex_wr_empty = force_empty || (rd_ptr == wr_ptr);
`ifdef DMA_WR_MASK_EN
  assign ex_wr_mask  = fifo_mask[rd_ptr[5:0]];
`endif

  logic [ADDR_W-1:0] exp_addr_q [$];
  beat_t             exp_data_q [$];
  int                n_checks = 0;
  int                n_pass   = 0;
  int                cmd_hs_cnt = 0;
  logic [7:0]        cmd_pat = 8'h01;
  int                cmd_period = 1;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic logic [DATA_W-1:0] rand256();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic pushWord(input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    beat_t b;
    fifo_data[wr_ptr[5:0]] = d;
    fifo_mask[wr_ptr[5:0]] = m;
    b.d = d;
`ifdef DMA_WR_MASK_EN
    b.m = m;
`else
    b.m = '0;
`endif
    exp_data_q.push_back(b);
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic loadBurst(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < int'(len); i++) begin
      pushWord(rand256(), (i == 0) ? MASK_W'(32'h0000000F) : MASK_W'($urandom));
      a = addr + ADDR_W'(i*8);
      exp_addr_q.push_back(a);
    end
  endtask

  task automatic waitBurstEnd(input bit drop_start, output int cycles);
    cycles = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge I_sys_clk);
      if (drop_start && k == 1) begin
        #1 ex_wr_start = 1'b0;
      end
      @(negedge I_sys_clk);
      if (ex_wr_burst_end) begin
        cycles = k;
        break;
      end
      checkOutput("start_ignored_busy", ex_wr_burst_start, 1'b0);
    end
    if (cycles == 0) begin
      n_checks++;
      $display("[TB] FAIL end_timeout: actual no burst_end required burst_end within 300 cycles");
    end
  endtask

  task automatic checkDrained(input string tag);
    checkOutput({tag, "_cmd_left"}, 256'(exp_addr_q.size()), 256'(0));
    checkOutput({tag, "_beat_left"}, 256'(exp_data_q.size()), 256'(0));
    checkOutput({tag, "_fifo_left"}, 256'(wr_ptr - rd_ptr), 256'(0));
  endtask

  task automatic applyStimulus(input vec_t v);
    int cyc;
    cmd_pat    = v.pat;
    cmd_period = v.period;
    loadBurst(v.addr, v.len);
    @(posedge I_sys_clk);
    #1;
    ex_wr_addr      = v.addr;
    ex_wr_burst_len = v.len;
    ex_wr_start     = 1'b1;
    @(negedge I_sys_clk);
    checkOutput("burst_start", ex_wr_burst_start, 1'b1);
    checkOutput("busy_at_accept", ex_wr_busy, 1'b0);
    waitBurstEnd(1'b1, cyc);
    if (v.exp_cyc > 0) checkOutput("end_latency", 256'(cyc), 256'(v.exp_cyc));
    @(negedge I_sys_clk);
    checkOutput("end_one_cycle", ex_wr_burst_end, 1'b0);
    checkOutput("idle_after_done", ex_wr_busy, 1'b0);
    checkDrained("burst");
  endtask

  // Command-ready pattern driver
  initial begin
    int cyc = 0;
    app_rdy = 1'b1;
    forever begin
      @(posedge I_sys_clk);
      #1;
      app_rdy = cmd_pat[cyc % cmd_period];
      cyc++;
    end
  end

  // FIFO pops on the clock edge where the data handshake completes
  initial begin
    forever begin
      @(posedge I_sys_clk);
      if (I_Rst_n && ex_wr_rd_en) rd_ptr <= rd_ptr + 1;
    end
  end

  // Scoreboard monitor: handshakes are visible on the falling edge before the accepting rising edge
  initial begin
    logic [ADDR_W-1:0] ea;
    beat_t eb;
    forever begin
      @(negedge I_sys_clk);
      if (I_Rst_n) begin
        checkOutput("wdf_end", app_wdf_end, app_wdf_wren);
        checkOutput("app_cmd", app_cmd, 3'b000);
        if (app_en && app_rdy) begin
          if (exp_addr_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL extra_cmd: actual addr %0h required no command", app_addr);
          end else begin
            ea = exp_addr_q.pop_front();
            checkOutput("app_addr", app_addr, ea);
            cmd_hs_cnt++;
          end
        end
        if (app_wdf_wren && app_wdf_rdy) begin
          checkOutput("rd_en_on_hs", ex_wr_rd_en, 1'b1);
          if (exp_data_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL extra_beat: actual data %0h required no beat", app_wdf_data);
          end else begin
            eb = exp_data_q.pop_front();
            checkOutput("wdf_data", app_wdf_data, eb.d);
            checkOutput("wdf_mask", app_wdf_mask, eb.m);
          end
        end else begin
          checkOutput("rd_en_no_hs", ex_wr_rd_en, 1'b0);
        end
        if (ex_wr_empty) checkOutput("wren_while_empty", app_wdf_wren, 1'b0);
      end
    end
  end

  initial begin
    vec_t vecs [5];
    int cyc;
    logic [DATA_W-1:0] held;

    vecs[0] = '{addr: 28'h0000100, len: 8'd4,  pat: 8'h01, period: 1, exp_cyc: 6};
    vecs[1] = '{addr: 28'h0002000, len: 8'd3,  pat: 8'h01, period: 3, exp_cyc: -1};
    vecs[2] = '{addr: 28'hFFFFFF8, len: 8'd2,  pat: 8'h01, period: 1, exp_cyc: 4};
    vecs[3] = '{addr: 28'h0000000, len: 8'd1,  pat: 8'h01, period: 1, exp_cyc: 3};
    vecs[4] = '{addr: 28'h1234560, len: 8'd16, pat: 8'h01, period: 1, exp_cyc: 18};

    I_Rst_n         = 1'b0;
    ex_wr_start     = 1'b0;
    ex_wr_addr      = '0;
    ex_wr_burst_len = '0;
    app_wdf_rdy     = 1'b1;

    repeat (3) @(posedge I_sys_clk);
    @(negedge I_sys_clk);
    checkOutput("rst_app_en", app_en, 1'b0);
    checkOutput("rst_app_addr", app_addr, '0);
    checkOutput("rst_busy", ex_wr_busy, 1'b0);
    checkOutput("rst_end", ex_wr_burst_end, 1'b0);
    checkOutput("rst_wren", app_wdf_wren, 1'b0);
    checkOutput("rst_rd_en", ex_wr_rd_en, 1'b0);
    checkOutput("rst_mask", app_wdf_mask, '0);
    @(posedge I_sys_clk);
    #1 I_Rst_n = 1'b1;

    $display("[TB] table-driven bursts");
    foreach (vecs[i]) applyStimulus(vecs[i]);

    $display("[TB] zero-length start");
    @(posedge I_sys_clk);
    #1;
    ex_wr_addr      = 28'h0000400;
    ex_wr_burst_len = 8'd0;
    ex_wr_start     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge I_sys_clk);
      checkOutput("len0_no_start", ex_wr_burst_start, 1'b0);
      checkOutput("len0_not_busy", ex_wr_busy, 1'b0);
      checkOutput("len0_no_cmd", app_en, 1'b0);
    end
    @(posedge I_sys_clk);
    #1 ex_wr_start = 1'b0;

    $display("[TB] data-side stall");
    cmd_pat = 8'h01; cmd_period = 1;
    loadBurst(28'h0000800, 8'd4);
    @(posedge I_sys_clk);
    #1;
    ex_wr_addr = 28'h0000800; ex_wr_burst_len = 8'd4; ex_wr_start = 1'b1;
    @(negedge I_sys_clk);
    checkOutput("stall_start", ex_wr_burst_start, 1'b1);
    @(posedge I_sys_clk);
    #1 ex_wr_start = 1'b0;
    @(posedge I_sys_clk);
    #1 force_empty = 1'b1;
    repeat (5) begin
      @(negedge I_sys_clk);
      checkOutput("stall_empty_wren", app_wdf_wren, 1'b0);
    end
    @(posedge I_sys_clk);
    #1;
    force_empty = 1'b0;
    app_wdf_rdy = 1'b0;
    @(negedge I_sys_clk);
    checkOutput("stall_wren_held", app_wdf_wren, 1'b1);
    held = app_wdf_data;
    @(posedge I_sys_clk);
    @(negedge I_sys_clk);
    checkOutput("stall_wren_held2", app_wdf_wren, 1'b1);
    checkOutput("stall_data_held", app_wdf_data, held);
    checkOutput("stall_no_pop", ex_wr_rd_en, 1'b0);
    checkOutput("stall_not_done", ex_wr_busy, 1'b1);
    @(posedge I_sys_clk);
    #1 app_wdf_rdy = 1'b1;
    waitBurstEnd(1'b0, cyc);
    @(negedge I_sys_clk);
    checkDrained("stall");

    $display("[TB] start held through burst and DONE");
    loadBurst(28'h0000C00, 8'd3);
    loadBurst(28'h0000C00, 8'd3);
    @(posedge I_sys_clk);
    #1;
    ex_wr_addr = 28'h0000C00; ex_wr_burst_len = 8'd3; ex_wr_start = 1'b1;
    @(negedge I_sys_clk);
    checkOutput("reentry_first_start", ex_wr_burst_start, 1'b1);
    waitBurstEnd(1'b0, cyc);
    checkOutput("reentry_first_latency", 256'(cyc), 256'(5));
    @(negedge I_sys_clk);
    checkOutput("reentry_second_start", ex_wr_burst_start, 1'b1);
    checkOutput("reentry_idle", ex_wr_busy, 1'b0);
    waitBurstEnd(1'b1, cyc);
    checkOutput("reentry_second_latency", 256'(cyc), 256'(5));
    @(negedge I_sys_clk);
    checkDrained("reentry");

    $display("[TB] reset mid-burst");
    loadBurst(28'h0001000, 8'd5);
    @(posedge I_sys_clk);
    #1;
    ex_wr_addr = 28'h0001000; ex_wr_burst_len = 8'd5; ex_wr_start = 1'b1;
    cyc = cmd_hs_cnt;
    @(posedge I_sys_clk);
    #1 ex_wr_start = 1'b0;
    for (int k = 0; k < 50 && cmd_hs_cnt < cyc + 2; k++) @(negedge I_sys_clk);
    checkOutput("rst_two_cmds_seen", 256'(cmd_hs_cnt - cyc), 256'(2));
    @(posedge I_sys_clk);
    #1 I_Rst_n = 1'b0;
    #1;
    checkOutput("midrst_app_en", app_en, 1'b0);
    checkOutput("midrst_app_addr", app_addr, '0);
    checkOutput("midrst_busy", ex_wr_busy, 1'b0);
    checkOutput("midrst_wren", app_wdf_wren, 1'b0);
    checkOutput("midrst_rd_en", ex_wr_rd_en, 1'b0);
    checkOutput("midrst_end", ex_wr_burst_end, 1'b0);
    checkOutput("midrst_start", ex_wr_burst_start, 1'b0);
    exp_addr_q.delete();
    exp_data_q.delete();
    wr_ptr = rd_ptr;
    repeat (2) @(posedge I_sys_clk);
    #1 I_Rst_n = 1'b1;
    applyStimulus('{addr: 28'h0000040, len: 8'd3, pat: 8'h01, period: 1, exp_cyc: 5});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/app_dma_wr.md
Name: app_dma_wr

Overview:
- DMA write engine between a first-word-fall-through (FWFT) source FIFO and the DDR3 MIG user interface.
- On a start request, issues a burst of write commands at consecutive addresses.
- Streams the matching write-data beats from the FIFO into the MIG write data FIFO.
- It is the write-direction counterpart of the read DMA engine. Both share the MIG app_* command port through the team's arbiter.

Parameters:
- ADDR_W, 28, MIG app_addr width.
- DATA_W, 256, MIG app data width. Mask width is DATA_W/8.
- LEN_W, 8, burst-length field width (number of commands/beats).
- ADDR_STEP, 8, address increment per command (BL8).

Ports:
- I_sys_clk  in  1  UI clock; all logic is on its rising edge.
- I_Rst_n  in  1  asynchronous, active-low reset.
- ex_wr_start  in  1  level request to start a burst; sampled only in IDLE.
- ex_wr_addr  in  ADDR_W  start address; latched on accept.
- ex_wr_burst_len  in  LEN_W  number of commands and beats; latched on accept.
- ex_wr_data  in  DATA_W  FWFT FIFO head word.
- ex_wr_empty  in  1  FIFO empty.
- ex_wr_rd_en  out  1  FIFO pop; high when a beat is accepted by the MIG.
- ex_wr_burst_start  out  1  one-cycle pulse; combinational, high on accept.
- ex_wr_burst_end  out  1  one-cycle pulse, registered.
- ex_wr_busy  out  1  high when state is not IDLE.
- app_addr  out  ADDR_W  command address.
- app_cmd  out  3  constant 3'b000 (write).
- app_en  out  1  command valid.
- app_rdy  in  1  command accepted when app_en and app_rdy are both high.
- app_wdf_data  out  DATA_W  equal to ex_wr_data.
- app_wdf_wren  out  1  write-data valid.
- app_wdf_end  out  1  equal to app_wdf_wren (one beat per burst).
- app_wdf_mask  out  DATA_W/8  byte mask.
- app_wdf_rdy  in  1  data accepted when app_wdf_wren and app_wdf_rdy are both high.

Behaviour:
- Reset (asynchronous, immediate, including mid-burst):
  - state=IDLE; app_en=0; app_addr=0; counters=0; ex_wr_burst_end=0.
  - All combinational outputs are therefore 0.
  - No partial-burst cleanup: the burst is abandoned.
- States:
  - IDLE -> XFER on accept.
  - XFER -> DONE when cmd_cnt==len and data_cnt==len.
  - DONE -> IDLE unconditionally after 1 cycle. ex_wr_burst_end=1 during DONE.
- Accept condition: state==IDLE, ex_wr_start=1 and ex_wr_burst_len!=0.
  - On accept, latch addr and len and clear both counters.
  - ex_wr_burst_start is high in the accept cycle.
  - ex_wr_burst_len==0 is ignored: no pulse, stays IDLE.
- Command path:
  - app_en rises in the cycle after accept and stays high until the len-th command handshake.
  - app_en drops in the cycle after that handshake.
  - app_addr starts at the latched address and increments by ADDR_STEP after each command handshake.
  - Address arithmetic is modulo 2^ADDR_W (wraps).
  - app_en and app_addr hold while app_rdy=0.
- Data path:
  - app_wdf_wren = (state==XFER) and (data_cnt<len) and !ex_wr_empty. Combinational: the FIFO is FWFT.
  - ex_wr_rd_en = app_wdf_wren and app_wdf_rdy.
  - data_cnt increments on each data handshake.
  - app_wdf_data and app_wdf_wren hold while app_wdf_rdy=0.
- Command and data paths are independent. Either may lead, per the MIG UI write rules.
- If the final command and final data handshakes land in the same cycle, DONE is entered next cycle.
- Latency: an idle, always-ready burst of N takes N+2 cycles from accept to the ex_wr_burst_end pulse.
- ex_wr_start while busy is ignored. A new accept is possible in the first IDLE cycle after DONE.
- Counter width is LEN_W. Maximum len is 2^LEN_W-1; no overflow.

Optional Feature:
- Macro: DMA_WR_MASK_EN.
- Defined:
  - Adds input port ex_wr_mask [DATA_W/8-1:0], read from the same FIFO word alongside ex_wr_data.
  - app_wdf_mask = ex_wr_mask.
- Undefined:
  - The ex_wr_mask port is absent.
  - app_wdf_mask is tied to all zeros (all bytes written).

Decomposition:
- Shared package dma_pkg:
  - APP_CMD_WR=3'b000 and APP_CMD_RD=3'b001.
  - ADDR_STEP default.
  - Write-FSM state encoding (IDLE, XFER, DONE).
- No sub-module. The block is a single FSM with two counters. The address/command logic is simple enough to stay inline.

Test Plan:
1. Accept, always ready: len=4, addr=0x100, app_rdy=app_wdf_rdy=1, FIFO non-empty.
   -> app_addr sequence 0x100/0x108/0x110/0x118; 4 wren beats; 4 pops; burst_end pulse 6 cycles after accept.
2. Command-side stall: app_rdy toggles 1,0,0,1..., len=3.
   -> app_addr/app_en hold during stalls; exactly 3 command handshakes; end pulse only after the 3rd command and 3rd beat.
3. Data-side stall: FIFO empty for 5 cycles mid-burst, then app_wdf_rdy=0 for 2 cycles.
   -> no wren while empty; wren and data held while not ready; ex_wr_rd_en only on handshakes; data_cnt reaches len exactly.
4. Degenerate and re-entry: len=0 start -> no burst_start, busy=0. Start asserted during XFER -> ignored. Start held through DONE -> new burst accepted in the first IDLE cycle.
5. Address wrap: addr=0xFFFFFF8, len=2 -> app_addr 0xFFFFFF8 then 0x0000000.
6. Reset and mask: I_Rst_n low mid-burst (cmd_cnt=2 of 5) -> all outputs 0 immediately; the next start behaves as a fresh burst. With DMA_WR_MASK_EN, mask 0x0000000F appears on app_wdf_mask with its beat.
